// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8-bit asynchronous serial transmitter.
// Bytes pushed with a one-cycle wr_en strobe are queued in a circular
// buffer and sent LSB-first as contiguous frames on tx (8N1 by default).
// Optional feature macro: UART_TX_PARITY_EN adds an even parity bit (8E1).
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wdata,
  input  logic               clr_ovrflw,
  output logic               tbr_valid,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]      CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Byte storage and queue bookkeeping
  logic [7:0]          mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    count;
  logic                full;
  logic                wr_ok;
  logic                pop;
  logic [7:0]          head;

  // Serialiser state
  state_t              state;
  logic [CW-1:0]       bit_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic                bit_done;
`ifdef UART_TX_PARITY_EN
  logic                parity_bit;
`endif

  assign full       = (count == FULL_CNT);
  assign wr_ok      = wr_en && !full;
  assign head       = mem[rd_ptr];
  assign bit_done   = (bit_cnt == '0);
  assign tbr_valid  = !full;
  assign busy       = (state != S_IDLE) || (count != '0);
  assign fifo_count = count;

  // Decide when the serialiser takes the head byte (idle, or end of a stop bit)
  always_comb begin
    pop = 1'b0;
    if (count != '0) begin
      if (state == S_IDLE)
        pop = 1'b1;
      else if (state == S_STOP && bit_done)
        pop = 1'b1;
    end
  end

  // Byte storage: written only on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wdata;
  end

  // Queue pointers and occupancy; fullness is judged on the registered count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a dropped write wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (wr_en && full)
      overflow <= 1'b1;
    else if (clr_ovrflw)
      overflow <= 1'b0;
  end

  // Frame sequencer with registered tx so the line never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= head;
            state   <= S_START;
            tx      <= 1'b0;
            bit_cnt <= CNT_MAX;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
          end
        end

        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shift[0];
            bit_cnt <= CNT_MAX;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end

        S_DATA: begin
          if (bit_done) begin
            bit_cnt <= CNT_MAX;
            shift   <= shift >> 1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_bit;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            state   <= S_STOP;
            tx      <= 1'b1;
            bit_cnt <= CNT_MAX;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_done) begin
            if (pop) begin
              // Next queued byte starts immediately: no idle gap between frames
              shift   <= head;
              state   <= S_START;
              tx      <= 1'b0;
              bit_cnt <= CNT_MAX;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^head;
`endif
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered. A line-level reference model (a queue of
// pending bytes plus a queue of per-clock line levels for the frame in
// flight) predicts tx, busy, tbr_valid, overflow and fifo_count every cycle.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wdata = 8'h00;
  logic          clr_ovrflw = 1'b0;
  logic          tbr_valid;
  logic          busy;
  logic          overflow;
  logic [AW:0]   fifo_count;
  logic          tx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wdata(wdata),
    .clr_ovrflw(clr_ovrflw),
    .tbr_valid(tbr_valid),
    .busy(busy),
    .overflow(overflow),
    .fifo_count(fifo_count),
    .tx(tx)
  );

  // Reference model state
  logic [7:0] mq[$];   // bytes waiting in the buffer
  bit         ml[$];   // remaining line levels of the frame in flight, one per clk
  bit         m_tx  = 1'b1;
  bit         m_act = 1'b0;
  bit         m_ovf = 1'b0;

  task automatic model_reset();
    mq.delete();
    ml.delete();
    m_tx  = 1'b1;
    m_act = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Expand one byte into its full frame of line levels and start it
  task automatic load_frame(input logic [7:0] b);
    bit lvl[$];
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) lvl.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    lvl.push_back(^b);
`endif
    lvl.push_back(1'b1);
    foreach (lvl[i]) repeat (CPB) ml.push_back(lvl[i]);
    m_tx  = ml.pop_front();
    m_act = 1'b1;
  endtask

  function automatic logic [AW+4:0] expect_vec();
    return {m_tx, (m_act || mq.size() != 0), (mq.size() != DEPTH), m_ovf,
            (AW+1)'(mq.size())};
  endfunction

  // One clock: drive inputs from the falling edge, advance the model at the
  // rising edge, return at the next falling edge with inputs released.
  task automatic tick(input bit w, input logic [7:0] d, input bit c);
    bit full;
    wr_en = w; wdata = d; clr_ovrflw = c;
    @(posedge clk);
    full = (mq.size() == DEPTH);
    if (ml.size() > 0) begin
      m_tx = ml.pop_front();
      m_act = 1'b1;
    end else if (mq.size() > 0) begin
      load_frame(mq.pop_front());
    end else begin
      m_tx = 1'b1;
      m_act = 1'b0;
    end
    if (w && full) m_ovf = 1'b1;
    else if (c)    m_ovf = 1'b0;
    if (w && !full) mq.push_back(d);
    if (w) $display("write 0x%02h %s", d, full ? "dropped" : "accepted");
    @(negedge clk);
    wr_en = 1'b0; clr_ovrflw = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx, busy, tbr_valid, overflow, fifo_count} !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", {tx, busy, tbr_valid, overflow, fifo_count},
               {1'b1, 1'b0, 1'b1, 1'b0, 5'd0});
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick(0, 8'h00, 0);
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    $display("test_reset complete");
  endtask

  task automatic test_single(input logic [7:0] b);
    int busy_cycles = 0;
    tick(1, b, 0);
    for (int i = 0; i < 50; i++) begin
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL single_%02h cyc=%0d got=%b want=%b", b, i, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
      if (busy) busy_cycles++;
      tick(0, 8'h00, 0);
    end
    // Busy from the cycle the byte is queued through the last stop-bit clock
`ifdef UART_TX_PARITY_EN
    total++;
    if (busy_cycles !== 11*CPB + 1) begin
      bad++;
      $display("FAIL single_busy_len got=%0d want=%0d", busy_cycles, 11*CPB + 1);
    end
`else
    total++;
    if (busy_cycles !== 10*CPB + 1) begin
      bad++;
      $display("FAIL single_busy_len got=%0d want=%0d", busy_cycles, 10*CPB + 1);
    end
`endif
    $display("test_single 0x%02h complete", b);
  endtask

  task automatic test_back_to_back();
    tick(1, 8'hA5, 0);
    tick(1, 8'h3C, 0);
    for (int i = 0; i < 100; i++) begin
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", i, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
      tick(0, 8'h00, 0);
    end
    $display("test_back_to_back complete");
  endtask

  task automatic test_fill_overflow();
    int guard = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick(1, 8'($urandom), 0);
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL fill cyc=%0d got=%b want=%b", i, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    total++;
    if ({overflow, tbr_valid, fifo_count} !== {1'b1, 1'b0, 5'd16}) begin
      bad++;
      $display("FAIL fill_full got=%b want=%b", {overflow, tbr_valid, fifo_count}, {1'b1, 1'b0, 5'd16});
    end
    while ((m_act || mq.size() != 0) && guard < 2000) begin
      tick(0, 8'h00, 0);
      guard++;
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL fill_drain cyc=%0d got=%b want=%b", guard, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    total++;
    if (busy !== 1'b0 || guard >= 2000) begin
      bad++;
      $display("FAIL fill_drain_end busy=%b cycles=%0d want busy=0", busy, guard);
    end
    $display("test_fill_overflow complete");
  endtask

  task automatic test_overflow_clear();
    int guard = 0;
    do_reset();
    for (int i = 0; i < 18; i++) tick(1, 8'(i), 0);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got=%b want=1", overflow);
    end
    tick(1, 8'hEE, 1);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set_beats_clr got=%b want=1", overflow);
    end
    tick(0, 8'h00, 1);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b want=0", overflow);
    end
    while ((m_act || mq.size() != 0) && guard < 2000) begin
      tick(0, 8'h00, 0);
      guard++;
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL ovf_drain cyc=%0d got=%b want=%b", guard, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    $display("test_overflow_clear complete");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    tick(1, 8'h00, 0);
    for (int i = 0; i < 5; i++) tick(1, 8'($urandom), 0);
    // Advance into data bit 3 of the 0x00 frame
    repeat (13) tick(0, 8'h00, 0);
    total++;
    if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
      bad++;
      $display("FAIL pre_reset got=%b want=%b", {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tx, busy, tbr_valid, overflow, fifo_count} !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", {tx, busy, tbr_valid, overflow, fifo_count},
               {1'b1, 1'b0, 1'b1, 1'b0, 5'd0});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(0, 8'h00, 0);
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL post_reset_quiet cyc=%0d got=%b want=%b", i, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    $display("test_reset_mid_frame complete");
  endtask

  task automatic test_random();
    int guard = 0;
    do_reset();
    for (int i = 0; i < 900; i++) begin
      tick(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    while ((m_act || mq.size() != 0) && guard < 2000) begin
      tick(0, 8'h00, 0);
      guard++;
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL random_drain cyc=%0d got=%b want=%b", guard, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    $display("test_random complete");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] b, input logic par);
    do_reset();
    tick(1, b, 0);
    // Parity bit occupies clocks 1+9*CPB .. 10*CPB after the write edge
    for (int i = 1; i <= 12*CPB; i++) begin
      tick(0, 8'h00, 0);
      if (i == 1 + 9*CPB + 1) begin
        total++;
        if (tx !== par) begin
          bad++;
          $display("FAIL parity_%02h got=%b want=%b", b, tx, par);
        end
      end
      total++;
      if ({tx, busy, tbr_valid, overflow, fifo_count} !== expect_vec()) begin
        bad++;
        $display("FAIL parity_frame_%02h cyc=%0d got=%b want=%b", b, i, {tx, busy, tbr_valid, overflow, fifo_count}, expect_vec());
      end
    end
    $display("test_parity 0x%02h complete", b);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(8'h55);
    test_single(8'($urandom));
    test_back_to_back();
    test_fill_overflow();
    test_overflow_clear();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
